// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end that shares one logical barrel
// shifter between the ALU issue path (0) and the branch/addr path (1).
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   reqN_valid/data/amount/type      requester N operation (N = 0, 1)
//   reqN_ready                       requester N accepted this cycle
//   sh_input/sh_amount/sh_type       registered operands to the shifter
//   sh_output                        shifter result (comb from sh_*)
//   rsp_valid/rsp_id/rsp_data        result, owner and handshake valid
//   rsp_ready                        consumer accepts the result
//   busy                             high whenever not IDLE
module shift_arbiter #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amount,
    input  logic [1:0]        req0_type,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amount,
    input  logic [1:0]        req1_type,
    output logic              req1_ready,
    output logic [DATA_W-1:0] sh_input,
    output logic [AMT_W-1:0]  sh_amount,
    output logic [1:0]        sh_type,
    input  logic [DATA_W-1:0] sh_output,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic [DATA_W-1:0] sh_input_q;
    logic [AMT_W-1:0]  sh_amount_q;
    logic [1:0]        sh_type_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic              idle;
    logic              any_valid;
    logic              sel;

    assign idle      = (state_q == IDLE);
    assign any_valid = req0_valid | req1_valid;

    // Contention alternates away from the last winner; a lone
    // requester always wins regardless of history.
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = ~last_grant_q;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    assign req0_ready = idle && req0_valid && !sel;
    assign req1_ready = idle && req1_valid && sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            sh_input_q   <= '0;
            sh_amount_q  <= '0;
            sh_type_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        sh_input_q   <= sel ? req1_data   : req0_data;
                        sh_amount_q  <= sel ? req1_amount : req0_amount;
                        sh_type_q    <= sel ? req1_type   : req0_type;
                        rsp_id_q     <= sel;
                        last_grant_q <= sel;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    // Shifter has had a full cycle on stable sh_* inputs.
                    rsp_data_q  <= sh_output;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sh_input  = sh_input_q;
    assign sh_amount = sh_amount_q;
    assign sh_type   = sh_type_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = !idle;

endmodule
